// File: rtl/fir_pkg.sv
// Shared defaults, FSM encoding and coefficient helpers for the FIR coefficient controller.
package fir_pkg;

  localparam int unsigned DEF_NUM_TAPS = 2;
  localparam int unsigned DEF_COEFF_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Tap-index width; a single-tap filter still carries a 1-bit address.
  function automatic int unsigned addr_w(input int unsigned taps);
    return (taps > 32'd1) ? 32'($clog2(taps)) : 32'd1;
  endfunction

  // Tap k of a bank packed with tap 0 in the low bits.
  function automatic logic [DEF_COEFF_W-1:0] coeff_at(
    input logic [DEF_NUM_TAPS*DEF_COEFF_W-1:0] bank,
    input int unsigned                         k
  );
    return bank[k*DEF_COEFF_W +: DEF_COEFF_W];
  endfunction

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient write / commit bus and filter control outputs of fir_coeff_ctrl.
interface fir_coeff_ctrl_if
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter int unsigned COEFF_W  = DEF_COEFF_W
) ();

  localparam int unsigned ADDR_W = addr_w(NUM_TAPS);

  logic                         i_wr_valid;
  logic                         o_wr_ready;
  logic [ADDR_W-1:0]            i_wr_addr;
  logic [COEFF_W-1:0]           i_wr_data;
  logic                         i_commit;
  logic [NUM_TAPS*COEFF_W-1:0]  o_coeffs;
  logic                         o_sample_en;
  logic                         o_flush;
  logic                         o_busy;
  logic                         o_err;

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_commit,
    input  o_wr_ready, o_coeffs, o_sample_en, o_flush, o_busy, o_err
  );

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_commit,
    output o_wr_ready, o_coeffs, o_sample_en, o_flush, o_busy, o_err
  );

endinterface

// File: rtl/sample_divider.sv
// Free-running 0..DIV-1 counter producing a registered one-clock sample strobe at DIV-1.
module sample_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic CLOCK_50,
  input  logic i_rst,
  output logic o_sample_en
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;

  always_comb count_d = (count == CNT_W'(DIV - 1)) ? '0 : count + CNT_W'(1);

  // Strobe is registered from the next count so it is high exactly while count==DIV-1.
  always_ff @(posedge CLOCK_50) begin
    if (i_rst) begin
      count       <= '0;
      o_sample_en <= 1'b0;
    end else begin
      count       <= count_d;
      o_sample_en <= (count_d == CNT_W'(DIV - 1));
    end
  end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient bank: writes land in a shadow bank, a commit swaps it
// into the active bank on the next sample strobe, followed by a tap-sum flush window.
module fir_coeff_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned                       NUM_TAPS     = DEF_NUM_TAPS,
  parameter int unsigned                       COEFF_W      = DEF_COEFF_W,
  parameter int unsigned                       DIV          = 4,
  parameter int unsigned                       FLUSH_CYCLES = 2,
  parameter logic [NUM_TAPS*COEFF_W-1:0]       RESET_COEFFS = {3'd2, 3'd3}
) (
  input logic             CLOCK_50,
  input logic             i_rst,
  fir_coeff_ctrl_if.slave bus
);

  localparam int unsigned ADDR_W = addr_w(NUM_TAPS);
  localparam int unsigned BANK_W = NUM_TAPS * COEFF_W;
  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [BANK_W-1:0]   shadow_q, active_q;
  logic                sample_en;
  logic                swap_c, wr_fire_c, addr_ok_c;
  logic                wr_ready_q, busy_q, flush_q, err_q;

  sample_divider #(.DIV(DIV)) u_div (
    .CLOCK_50    (CLOCK_50),
    .i_rst       (i_rst),
    .o_sample_en (sample_en)
  );

  assign wr_fire_c = bus.i_wr_valid && wr_ready_q;
  assign addr_ok_c = (32'(bus.i_wr_addr) < NUM_TAPS);

  always_ff @(posedge CLOCK_50) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Commit only arms; the swap itself is aligned to the strobe seen while ARMED.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    swap_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_commit) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (sample_en) begin
          swap_c      = 1'b1;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FCNT_W'(FLUSH_CYCLES - 1)) state_d = ST_IDLE;
        else flush_cnt_d = flush_cnt_q + FCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track the state register exactly.
  always_ff @(posedge CLOCK_50) begin
    if (i_rst) begin
      shadow_q   <= RESET_COEFFS;
      active_q   <= RESET_COEFFS;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ready_q <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      flush_q    <= (state_d == ST_FLUSH);
      if (swap_c) active_q <= shadow_q;
      if (wr_fire_c && !addr_ok_c) err_q <= 1'b1;
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (wr_fire_c && (bus.i_wr_addr == ADDR_W'(k)))
          shadow_q[k*COEFF_W +: COEFF_W] <= bus.i_wr_data;
      end
    end
  end

  assign bus.o_coeffs    = active_q;
  assign bus.o_sample_en = sample_en;
  assign bus.o_wr_ready  = wr_ready_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_flush     = flush_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: expected banks and swap cycles are queued at commit
// time and checked when the flush window opens.
module tb_fir_coeff_ctrl;
  import fir_pkg::*;

  localparam int unsigned DIV          = 4;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam logic [5:0]  RST_BANK     = {3'd2, 3'd3};
  localparam logic [8:0]  RST_BANK2    = {3'd1, 3'd4, 3'd6};

  typedef struct {
    logic [5:0] bank;
    int         vis_cyc;
  } swap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_coeff_ctrl_if #(.NUM_TAPS(2), .COEFF_W(3)) bus  ();
  fir_coeff_ctrl_if #(.NUM_TAPS(3), .COEFF_W(3)) bus2 ();

  fir_coeff_ctrl #(
    .NUM_TAPS(2), .COEFF_W(3), .DIV(DIV), .FLUSH_CYCLES(FLUSH_CYCLES), .RESET_COEFFS(RST_BANK)
  ) dut (
    .CLOCK_50 (clk),
    .i_rst    (rst),
    .bus      (bus)
  );

  fir_coeff_ctrl #(
    .NUM_TAPS(3), .COEFF_W(3), .DIV(DIV), .FLUSH_CYCLES(FLUSH_CYCLES), .RESET_COEFFS(RST_BANK2)
  ) dut2 (
    .CLOCK_50 (clk),
    .i_rst    (rst),
    .bus      (bus2)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  swap_t      sb[$];
  logic [5:0] shadow_m;
  logic [5:0] active_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Cycle in which a commit issued in cycle c becomes visible on o_coeffs.
  function automatic int vis_cycle(input int c);
    int s = c + 1;
    while ((s % DIV) != (DIV - 1)) s++;
    return s + 1;
  endfunction

  task automatic write(input int addr, input logic [2:0] data);
    check("wr_ready_idle", 32'(bus.o_wr_ready), 32'd1);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 1'(addr);
    bus.i_wr_data  = data;
    shadow_m[addr*3 +: 3] = data;
    tick();
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic commit_now();
    swap_t e;
    e.bank    = shadow_m;
    e.vis_cyc = vis_cycle(cyc);
    sb.push_back(e);
    bus.i_commit = 1'b1;
    tick();
    bus.i_commit = 1'b0;
  endtask

  task automatic await_swap(input string tag, input bit full);
    swap_t e;
    bit    seen = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 4 * DIV && !seen; i++) begin
      if (bus.o_flush === 1'b1) seen = 1'b1;
      else begin
        check({tag, "_hold"}, 32'(bus.o_coeffs), 32'(active_m));
        tick();
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_cycle"}, 32'(cyc), 32'(e.vis_cyc));
    check({tag, "_coeffs"}, 32'(bus.o_coeffs), 32'(e.bank));
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
    active_m = e.bank;
    if (full) begin
      for (int i = 1; i < FLUSH_CYCLES; i++) begin
        tick();
        check({tag, "_flush_on"}, 32'(bus.o_flush), 32'd1);
      end
      tick();
      check({tag, "_flush_off"}, 32'(bus.o_flush), 32'd0);
      check({tag, "_ready"}, 32'(bus.o_wr_ready), 32'd1);
      check({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
    end
  endtask

  initial begin
    bit seen2;
    rst = 1'b1;
    bus.i_wr_valid  = 1'b0; bus.i_wr_addr  = '0; bus.i_wr_data  = '0; bus.i_commit  = 1'b0;
    bus2.i_wr_valid = 1'b0; bus2.i_wr_addr = '0; bus2.i_wr_data = '0; bus2.i_commit = 1'b0;
    shadow_m = RST_BANK;
    active_m = RST_BANK;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Reset values
    check("rst_coeffs", 32'(bus.o_coeffs), 32'(RST_BANK));
    check("rst_sample_en", 32'(bus.o_sample_en), 32'd0);
    check("rst_flush", 32'(bus.o_flush), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_ready", 32'(bus.o_wr_ready), 32'd1);
    check("rst_err", 32'(bus.o_err), 32'd0);

    // Twelve idle clocks: strobe only at cycles 3, 7, 11
    for (int i = 0; i < 12; i++) begin
      check("idle_strobe", 32'(bus.o_sample_en), 32'((cyc % DIV) == (DIV - 1)));
      check("idle_flush", 32'(bus.o_flush), 32'd0);
      check("idle_tap0", 32'(coeff_at(bus.o_coeffs, 0)), 32'd3);
      check("idle_tap1", 32'(coeff_at(bus.o_coeffs, 1)), 32'd2);
      if (i < 11) tick();
    end

    // Two writes, commit at count 0
    tick();
    write(0, 3'd5);
    write(1, 3'd1);
    tick();
    tick();
    check("commit_phase", 32'(cyc % DIV), 32'd0);
    commit_now();
    check("armed_busy", 32'(bus.o_busy), 32'd1);
    check("armed_not_ready", 32'(bus.o_wr_ready), 32'd0);
    await_swap("swap1", 1'b1);

    // Write and commit in the same cycle
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = 1'b1; bus.i_wr_data = 3'd7;
    shadow_m[3 +: 3] = 3'd7;
    commit_now();
    bus.i_wr_valid = 1'b0;
    await_swap("swap2", 1'b1);

    // Commit while the strobe is high waits for the next strobe
    write(0, 3'd2);
    check("strobe_at_commit", 32'(bus.o_sample_en), 32'd1);
    commit_now();
    await_swap("swap3", 1'b1);

    // Write held through ARMED/FLUSH is accepted in the first IDLE cycle
    commit_now();
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = 1'b1; bus.i_wr_data = 3'd4;
    check("held_not_ready", 32'(bus.o_wr_ready), 32'd0);
    await_swap("swap4", 1'b1);
    shadow_m[3 +: 3] = 3'd4;
    tick();
    bus.i_wr_valid = 1'b0;
    commit_now();
    await_swap("swap5", 1'b1);

    // Reset in the middle of a flush
    write(0, 3'd6);
    commit_now();
    await_swap("swap6", 1'b0);
    rst = 1'b1;
    tick();
    check("rflush_flush", 32'(bus.o_flush), 32'd0);
    check("rflush_coeffs", 32'(bus.o_coeffs), 32'(RST_BANK));
    check("rflush_busy", 32'(bus.o_busy), 32'd0);
    check("rflush_ready", 32'(bus.o_wr_ready), 32'd1);
    check("rflush_strobe", 32'(bus.o_sample_en), 32'd0);
    rst = 1'b0;
    cyc = 0;
    shadow_m = RST_BANK;
    active_m = RST_BANK;
    for (int i = 0; i < 5; i++) begin
      check("restart_strobe", 32'(bus.o_sample_en), 32'(i == 3));
      tick();
    end
    // Shadow edits from before the reset must be gone
    commit_now();
    await_swap("swap_after_rst", 1'b1);

    // Out-of-range write on the 3-tap instance
    check("t3_ready", 32'(bus2.o_wr_ready), 32'd1);
    bus2.i_wr_valid = 1'b1; bus2.i_wr_addr = 2'd3; bus2.i_wr_data = 3'd7;
    tick();
    bus2.i_wr_valid = 1'b0;
    check("t3_err_set", 32'(bus2.o_err), 32'd1);
    check("t2_err_clear", 32'(bus.o_err), 32'd0);
    bus2.i_wr_valid = 1'b1; bus2.i_wr_addr = 2'd1; bus2.i_wr_data = 3'd5;
    tick();
    bus2.i_wr_valid = 1'b0;
    check("t3_err_sticky", 32'(bus2.o_err), 32'd1);
    bus2.i_commit = 1'b1;
    tick();
    bus2.i_commit = 1'b0;
    seen2 = 1'b0;
    for (int i = 0; i < 4 * DIV && !seen2; i++) begin
      if (bus2.o_flush === 1'b1) seen2 = 1'b1;
      else begin
        check("t3_hold", 32'(bus2.o_coeffs), 32'(RST_BANK2));
        tick();
      end
    end
    check("t3_swap_seen", 32'(seen2), 32'd1);
    check("t3_swap_cycle", 32'(cyc), 32'd16);
    check("t3_coeffs", 32'(bus2.o_coeffs), 32'(9'b001_101_110));
    check("t3_err_after", 32'(bus2.o_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
